// File: rtl/ft245_pkg.sv
// Shared FSM state encodings (also decoded by the debug LED map) and default
// FT245 strobe timing.
package ft245_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_LOW   = 3'd1;
  localparam logic [2:0] ST_RD_HIGH  = 3'd2;
  localparam logic [2:0] ST_WR_SETUP = 3'd3;
  localparam logic [2:0] ST_WR_LOW   = 3'd4;
  localparam logic [2:0] ST_WR_HIGH  = 3'd5;

  localparam int RD_LOW_CYCLES_DEF   = 4;
  localparam int RD_HIGH_CYCLES_DEF  = 5;
  localparam int WR_SETUP_CYCLES_DEF = 1;
  localparam int WR_LOW_CYCLES_DEF   = 3;
  localparam int WR_HIGH_CYCLES_DEF  = 4;

endpackage

// File: rtl/ft245_fifo_port_sync.sv
// Generic multi-bit two-flop synchronizer for independent asynchronous
// level signals; reset value selectable so flags come up inactive.
module synchronizer #(
  parameter int              WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft245_fifo_port.sv
// FT245 USB FIFO pin engine: counter-timed RD#/WR# strobes, one-byte RX
// buffer on a valid/ready stream, TX valid/ready intake, bus direction control.
module ft245_fifo_port
  import ft245_pkg::*;
#(
  parameter int RD_LOW_CYCLES   = RD_LOW_CYCLES_DEF,
  parameter int RD_HIGH_CYCLES  = RD_HIGH_CYCLES_DEF,
  parameter int WR_SETUP_CYCLES = WR_SETUP_CYCLES_DEF,
  parameter int WR_LOW_CYCLES   = WR_LOW_CYCLES_DEF,
  parameter int WR_HIGH_CYCLES  = WR_HIGH_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxf_n_raw,
  input  logic       txe_n_raw,
  input  logic [7:0] data_bus_in_raw,
  output logic [7:0] data_bus_out,
  output logic       data_out_enable,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [2:0] state_out
);

  localparam logic [3:0] RD_LOW_LOAD   = 4'(RD_LOW_CYCLES - 1);
  localparam logic [3:0] RD_HIGH_LOAD  = 4'(RD_HIGH_CYCLES - 1);
  localparam logic [3:0] WR_SETUP_LOAD = 4'(WR_SETUP_CYCLES - 1);
  localparam logic [3:0] WR_LOW_LOAD   = 4'(WR_LOW_CYCLES - 1);
  localparam logic [3:0] WR_HIGH_LOAD  = 4'(WR_HIGH_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       last_rx;
  logic [1:0] flags_s;
  logic       rxf_s, txe_s;
  logic       rx_possible, tx_possible, grant_rx, grant_tx;

  // Flags reset to 1 (inactive) so nothing starts until the pins are re-read.
  synchronizer #(.WIDTH(2), .RESET_VALUE(2'b11)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({rxf_n_raw, txe_n_raw}),
    .q       (flags_s)
  );

  assign rxf_s = flags_s[1];
  assign txe_s = flags_s[0];

  assign rx_possible = !rxf_s && !rx_valid;
  assign tx_possible = !txe_s && tx_valid;
  // With both requesting, serve whichever side was not served last.
  assign grant_rx    = rx_possible && (!tx_possible || !last_rx);
  assign grant_tx    = tx_possible && (!rx_possible || last_rx);
  assign tx_ready    = (state == ST_IDLE) && grant_tx;
  assign state_out   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      last_rx         <= 1'b0;
      rd_n            <= 1'b1;
      wr_n            <= 1'b1;
      data_out_enable <= 1'b0;
      data_bus_out    <= '0;
      rx_valid        <= 1'b0;
      rx_data         <= '0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_rx) begin
            rd_n    <= 1'b0;
            cnt     <= RD_LOW_LOAD;
            last_rx <= 1'b1;
            state   <= ST_RD_LOW;
          end else if (grant_tx) begin
            data_bus_out    <= tx_data;
            data_out_enable <= 1'b1;
            cnt             <= WR_SETUP_LOAD;
            last_rx         <= 1'b0;
            state           <= ST_WR_SETUP;
          end
        end
        ST_RD_LOW: begin
          if (cnt == '0) begin
            rd_n     <= 1'b1;
            rx_data  <= data_bus_in_raw;
            rx_valid <= 1'b1;
            cnt      <= RD_HIGH_LOAD;
            state    <= ST_RD_HIGH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RD_HIGH: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 4'd1;
        end
        ST_WR_SETUP: begin
          if (cnt == '0) begin
            wr_n  <= 1'b0;
            cnt   <= WR_LOW_LOAD;
            state <= ST_WR_LOW;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR_LOW: begin
          if (cnt == '0) begin
            wr_n  <= 1'b1;
            cnt   <= WR_HIGH_LOAD;
            state <= ST_WR_HIGH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR_HIGH: begin
          // Bus held through the first recovery cycle for FT245 data hold time.
          data_out_enable <= 1'b0;
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_fifo_port.sv
// Self-checking bench for ft245_fifo_port: scenario tasks plus a byte
// scoreboard on the rx stream and on the bus at each wr_n fall.
module tb_ft245_fifo_port;
  import ft245_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxf_n_raw = 1'b1;
  logic       txe_n_raw = 1'b1;
  logic [7:0] data_bus_in_raw = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] data_bus_out;
  logic       data_out_enable;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [2:0] state_out;

  int total = 0;
  int bad = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         order_q[$];

  ft245_fifo_port dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rxf_n_raw       (rxf_n_raw),
    .txe_n_raw       (txe_n_raw),
    .data_bus_in_raw (data_bus_in_raw),
    .data_bus_out    (data_bus_out),
    .data_out_enable (data_out_enable),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .state_out       (state_out)
  );

  always #5 clk = ~clk;

  // Scoreboard pops and protocol invariants, sampled mid-cycle.
  logic [7:0] mon_exp;
  logic       mon_prev_wr = 1'b1;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      total++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: got %h want no byte", rx_data);
      end else begin
        mon_exp = rx_q.pop_front();
        if (rx_data !== mon_exp) begin
          bad++;
          $display("FAIL rx_byte: got %h want %h", rx_data, mon_exp);
        end
      end
    end
    if (!wr_n && mon_prev_wr) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %h want no write", data_bus_out);
      end else begin
        mon_exp = tx_q.pop_front();
        if (data_bus_out !== mon_exp || data_out_enable !== 1'b1) begin
          bad++;
          $display("FAIL tx_byte: got %h oe=%b want %h oe=1", data_bus_out, data_out_enable, mon_exp);
        end
      end
    end
    mon_prev_wr = wr_n;
    total++;
    if (!rd_n && !wr_n) begin
      bad++;
      $display("FAIL strobe_overlap: got rd_n=%b wr_n=%b want not both 0", rd_n, wr_n);
    end
    total++;
    if (data_out_enable && !rd_n) begin
      bad++;
      $display("FAIL bus_contention: got oe=%b rd_n=%b want oe=0 while rd_n=0", data_out_enable, rd_n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rxf_n_raw = 1'b0;
    txe_n_raw = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    repeat (3) @(negedge clk);
    total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n: got %b want 1", rd_n); end
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n: got %b want 1", wr_n); end
    total++; if (data_out_enable !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", data_out_enable); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    total++; if (state_out !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_out, ST_IDLE); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (data_bus_out !== 8'h00) begin bad++; $display("FAIL reset_bus_out: got %h want 00", data_bus_out); end
    rxf_n_raw = 1'b1;
    txe_n_raw = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    step();
    reset_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_single_read();
    logic exp_rd;
    data_bus_in_raw = 8'hA5;
    rx_ready = 1'b1;
    rx_q.push_back(8'hA5);
    step();
    rxf_n_raw = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      exp_rd = !(i >= 3 && i <= 6);
      total++;
      if (rd_n !== exp_rd) begin bad++; $display("FAIL read_rd_n[%0d]: got %b want %b", i, rd_n, exp_rd); end
      total++;
      if (rx_valid !== (i == 7)) begin bad++; $display("FAIL read_rx_valid[%0d]: got %b want %b", i, rx_valid, (i == 7)); end
      if (i == 7) begin
        total++;
        if (rx_data !== 8'hA5) begin bad++; $display("FAIL read_rx_data: got %h want a5", rx_data); end
      end
      if (i == 4) rxf_n_raw = 1'b1;
    end
    repeat (8) step();
    @(negedge clk);
    total++; if (state_out !== ST_IDLE || rd_n !== 1'b1) begin bad++; $display("FAIL read_return_idle: got state=%0d rd_n=%b want state=0 rd_n=1", state_out, rd_n); end
    rx_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int  pulses;
    int  n;
    bit  got;
    logic prev;
    data_bus_in_raw = 8'h5A;
    rx_q.push_back(8'h5A);
    step();
    rxf_n_raw = 1'b0;
    pulses = 0;
    prev = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rd_n && prev) pulses++;
      prev = rd_n;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL bp_pulse_count: got %0d want 1", pulses); end
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin bad++; $display("FAIL bp_held: got valid=%b data=%h want valid=1 data=5a", rx_valid, rx_data); end
    data_bus_in_raw = 8'h6B;
    rx_q.push_back(8'h6B);
    step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (!rd_n) begin got = 1'b1; n = i; end
    end
    total++; if (!got || n > 4) begin bad++; $display("FAIL bp_restart: got found=%b after %0d want found=1 within 4", got, n); end
    step();
    rxf_n_raw = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL bp_second_valid: got %b want 1", got); end
    step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL bp_consumed: got %b want 0", rx_valid); end
    repeat (8) step();
  endtask

  task automatic test_single_write();
    int   ready_cnt;
    bit   got;
    logic exp_wr;
    logic exp_oe;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tx_q.push_back(8'h3C);
    step();
    txe_n_raw = 1'b0;
    ready_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (tx_ready) begin ready_cnt++; got = 1'b1; end
    end
    total++; if (!got) begin bad++; $display("FAIL wr_accept: got %b want 1", got); end
    step();
    txe_n_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (tx_ready) ready_cnt++;
      exp_wr = !(i >= 2 && i <= 4);
      exp_oe = (i <= 5);
      total++;
      if (wr_n !== exp_wr) begin bad++; $display("FAIL wr_wr_n[%0d]: got %b want %b", i, wr_n, exp_wr); end
      total++;
      if (data_out_enable !== exp_oe) begin bad++; $display("FAIL wr_oe[%0d]: got %b want %b", i, data_out_enable, exp_oe); end
      if (exp_oe) begin
        total++;
        if (data_bus_out !== 8'h3C) begin bad++; $display("FAIL wr_bus[%0d]: got %h want 3c", i, data_bus_out); end
      end
    end
    total++; if (ready_cnt !== 1) begin bad++; $display("FAIL wr_ready_pulses: got %0d want 1", ready_cnt); end
    tx_valid = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_contention();
    int  seen;
    bit  accepted;
    bit  exp_side;
    logic prev_rd;
    logic prev_wr;
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    order_q.push_back(1'b0);
    order_q.push_back(1'b1);
    data_bus_in_raw = 8'hC3;
    tx_data = 8'h96;
    tx_valid = 1'b1;
    rx_ready = 1'b1;
    step();
    rxf_n_raw = 1'b0;
    txe_n_raw = 1'b0;
    seen = 0;
    prev_rd = 1'b1;
    prev_wr = 1'b1;
    for (int c = 0; c < 200 && seen < 4; c++) begin
      @(negedge clk);
      accepted = 1'b0;
      if (tx_valid && tx_ready) begin
        tx_q.push_back(tx_data);
        accepted = 1'b1;
      end
      if ((!rd_n && prev_rd) || (!wr_n && prev_wr)) begin
        total++;
        if (order_q.size() == 0) begin
          bad++;
          $display("FAIL cont_extra_strobe: got rd_n=%b wr_n=%b want none", rd_n, wr_n);
        end else begin
          exp_side = order_q.pop_front();
          if (wr_n !== !exp_side || rd_n !== exp_side) begin
            bad++;
            $display("FAIL cont_order[%0d]: got rd_n=%b wr_n=%b want write=%b", seen, rd_n, wr_n, exp_side);
          end
        end
        if (!rd_n) rx_q.push_back(8'hC3);
        seen++;
      end
      prev_rd = rd_n;
      prev_wr = wr_n;
      step();
      if (accepted) tx_data = tx_data + 8'h11;
    end
    total++; if (seen < 4) begin bad++; $display("FAIL cont_timeout: got %0d strobes want 4", seen); end
    rxf_n_raw = 1'b1;
    txe_n_raw = 1'b1;
    tx_valid = 1'b0;
    repeat (30) step();
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL cont_rx_drain: got %0d left want 0", rx_q.size()); end
    total++; if (tx_q.size() != 0) begin bad++; $display("FAIL cont_tx_drain: got %0d left want 0", tx_q.size()); end
    total++; if (order_q.size() != 0) begin bad++; $display("FAIL cont_order_drain: got %0d left want 0", order_q.size()); end
  endtask

  task automatic test_reset_mid_op();
    bit got;
    data_bus_in_raw = 8'hE7;
    rx_ready = 1'b1;
    step();
    rxf_n_raw = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!rd_n) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL mid_first_fall: got %b want 1", got); end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL mid_rd_release: got %b want 1", rd_n); end
    total++; if (state_out !== ST_IDLE) begin bad++; $display("FAIL mid_state: got %0d want %0d", state_out, ST_IDLE); end
    repeat (3) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid: got %b want 0", rx_valid); end
    step();
    reset_n = 1'b1;
    rx_q.push_back(8'hE7);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("FAIL mid_reread: got %b want 1", got); end
    total++; if (rx_data !== 8'hE7) begin bad++; $display("FAIL mid_reread_data: got %h want e7", rx_data); end
    rxf_n_raw = 1'b1;
    repeat (10) step();
    rx_ready = 1'b0;
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL mid_rx_drain: got %0d left want 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_backpressure();
    test_single_write();
    test_contention();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
